// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, response and data_memory signal bundle for load_store_unit
interface load_store_unit_if;
  // pipeline request
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // writeback response
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // data_memory port
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store sequencer with sub-word RMW; option macro LSU_ALIGN_TRAP_EN
module load_store_unit #(
  parameter int WORD_ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_t;

  state_t                   state;
  state_t                   state_nx;
  logic                     accept;
  logic                     req_err;
  logic [1:0]               eff_off;
  logic [1:0]               size_q;
  logic                     uns_q;
  logic [1:0]               off_q;
  logic [WORD_ADDR_W-1:0]   idx_q;
  logic [31:0]              wbuf_q;
  logic [31:0]              rdata_q;
  logic                     err_q;
  logic                     unused_addr_hi;

  // address bits above the word index wrap away
  assign unused_addr_hi = ^bus.req_addr[31:WORD_ADDR_W+2];

  assign accept = bus.req_valid && (state == IDLE);

  // extend the addressed lane of a read word
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic uns, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_ext = {{24{b[7] & ~uns}}, b};
      2'b01:   load_ext = {{16{h[15] & ~uns}}, h};
      default: load_ext = word;
    endcase
  endfunction

  // replace only the addressed lane of the old word with store data
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] size, input logic [1:0] off);
    logic [31:0] m;
    m = old;
    case (size)
      2'b00:   m[{off, 3'b000} +: 8]     = wd[7:0];
      2'b01:   m[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: m = wd;
    endcase
    return m;
  endfunction

  // classify the incoming request: error and effective lane offset
  always_comb begin
    req_err = (bus.req_size == 2'b11);
    eff_off = bus.req_addr[1:0];
`ifdef LSU_ALIGN_TRAP_EN
    if ((bus.req_size == 2'b01 && bus.req_addr[0]) ||
        (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end
`else
    if (bus.req_size == 2'b01) begin
      eff_off = {bus.req_addr[1], 1'b0};
    end else if (bus.req_size == 2'b10) begin
      eff_off = 2'b00;
    end
`endif
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_nx = DONE;
          end else if (bus.req_store) begin
            state_nx = (bus.req_size == 2'b10) ? WRITE : RMW_RD;
          end else begin
            state_nx = LOAD;
          end
        end
      end
      LOAD:    state_nx = DONE;
      RMW_RD:  state_nx = WRITE;
      WRITE:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state-decoded outputs; memory bus idles at zero outside an access
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.mem_read   = (state == LOAD) || (state == RMW_RD);
    bus.mem_write  = (state == WRITE);
    bus.mem_addr   = 32'd0;
    bus.mem_wdata  = 32'd0;
    bus.resp_valid = (state == DONE);
    bus.resp_rdata = 32'd0;
    bus.resp_err   = 1'b0;
    if (bus.mem_read || bus.mem_write) begin
      bus.mem_addr = {{(32-WORD_ADDR_W){1'b0}}, idx_q};
    end
    if (state == WRITE) begin
      bus.mem_wdata = wbuf_q;
    end
    if (state == DONE) begin
      bus.resp_rdata = rdata_q;
      bus.resp_err   = err_q;
    end
  end

  // request latch, load capture and RMW merge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      idx_q   <= '0;
      wbuf_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            off_q   <= eff_off;
            idx_q   <= bus.req_addr[WORD_ADDR_W+1:2];
            wbuf_q  <= bus.req_wdata;
            rdata_q <= 32'd0;
            err_q   <= req_err;
          end
        end
        LOAD:    rdata_q <= load_ext(bus.mem_rdata, size_q, uns_q, off_q);
        RMW_RD:  wbuf_q  <= merge(bus.mem_rdata, wbuf_q, size_q, off_q);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with data_memory and reference model
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.WORD_ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // data_memory stand-in with preload port and access monitors
  logic [31:0] mem [1024];
  logic        pre_en = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic [31:0] last_raddr = '0;
  logic [31:0] acc_q [$];

  assign bus.mem_rdata = mem[bus.mem_addr[9:0]];

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_idx] <= pre_data;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= bus.mem_addr;
      last_wdata <= bus.mem_wdata;
    end
    if (bus.mem_read) begin
      rd_cnt     <= rd_cnt + 1;
      last_raddr <= bus.mem_addr;
    end
    if (bus.mem_read && bus.mem_write) both_cnt <= both_cnt + 1;
    if (rst_n && bus.req_valid && bus.req_ready) acc_q.push_back(bus.req_addr);
  end

  int          tests = 0;
  int          fails = 0;
  logic [31:0] ref_mem [1024];
  logic [31:0] g_rdata;
  logic        g_err;
  int          g_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // architectural reference: what a byte-addressed load/store does to a word array
  function automatic void ref_op(input logic st, input logic [1:0] sz, input logic un,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic [31:0] rd, output logic er,
                                 output int lat, output int nr, output int nw);
    int          off;
    int          idx;
    logic [31:0] mask;
    logic [31:0] v;
    idx = int'(a[11:2]);
    off = int'(a[1:0]);
    er  = (sz == 2'b11);
`ifdef LSU_ALIGN_TRAP_EN
    if ((sz == 2'b01 && off % 2 != 0) || (sz == 2'b10 && off != 0)) er = 1'b1;
`else
    if (sz == 2'b01) off = off - (off % 2);
    if (sz == 2'b10) off = 0;
`endif
    rd = 32'd0; lat = 1; nr = 0; nw = 0;
    if (er) return;
    mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    if (st) begin
      ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      nw  = 1;
      nr  = (sz == 2'b10) ? 0 : 1;
      lat = (sz == 2'b10) ? 2 : 3;
    end else begin
      v = (ref_mem[idx] >> (8 * off)) & mask;
      if (!un && sz == 2'b00 && v[7])  v = v | ~mask;
      if (!un && sz == 2'b01 && v[15]) v = v | ~mask;
      rd  = v;
      lat = 2;
      nr  = 1;
    end
  endfunction

  task automatic run_req(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic [31:0] e_rd;
    logic        e_er;
    int          e_lat, e_nr, e_nw, r0, w0, k;
    logic        seen;
    logic [9:0]  idx;
    ref_op(st, sz, un, a, wd, e_rd, e_er, e_lat, e_nr, e_nw);
    idx = a[11:2];
    @(negedge clk);
    chk({tag, "_ready"}, bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_size = sz;
    bus.req_unsigned = un; bus.req_addr = a; bus.req_wdata = wd;
    r0 = rd_cnt; w0 = wr_cnt;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    seen = 1'b0; k = 0; g_rdata = 'x; g_err = 1'bx;
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      if (bus.resp_valid) begin
        seen = 1'b1; g_rdata = bus.resp_rdata; g_err = bus.resp_err;
      end
    end
    g_lat = k;
    chk({tag, "_lat"}, k, e_lat);
    chk({tag, "_rdata"}, g_rdata, e_rd);
    chk({tag, "_err"}, g_err, e_er);
    chk({tag, "_reads"}, rd_cnt - r0, e_nr);
    chk({tag, "_writes"}, wr_cnt - w0, e_nw);
    chk({tag, "_memword"}, mem[idx], ref_mem[idx]);
    @(negedge clk);
    chk({tag, "_pulse"}, bus.resp_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t6_addr [3];
    logic [31:0] t6_exp [$];
    logic [31:0] t6_got [$];
    logic [31:0] d_rd;
    logic        d_er;
    int          d_lat, d_nr, d_nw, w0, i, bad_ready, acc_base;
    logic        busy;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    // preload memory while reset is held
    for (int n = 0; n < 1024; n++) begin
      @(negedge clk);
      pre_en = 1'b1; pre_idx = 10'(n); pre_data = $urandom;
      ref_mem[n] = pre_data;
    end
    @(negedge clk);
    pre_en = 1'b0;
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    rst_n = 1'b1;

    // SW, sub-word loads, SB merge
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, "sw10");
    chk("sw10_waddr", last_waddr, 32'd4);
    chk("sw10_lat_c", g_lat, 2);
    run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, "lb13");
    chk("lb13_c", g_rdata, 32'hFFFFFFDE);
    run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, "lbu13");
    chk("lbu13_c", g_rdata, 32'h000000DE);
    run_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, "lh10");
    chk("lh10_c", g_rdata, 32'hFFFFBEEF);
    run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h55, "sb11");
    chk("sb11_wdata", last_wdata, 32'hDEAD55EF);
    chk("sb11_lat_c", g_lat, 3);

    // misaligned word
    run_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, "lw12");
`ifdef LSU_ALIGN_TRAP_EN
    chk("lw12_err_c", g_err, 1);
    chk("lw12_lat_c", g_lat, 1);
`else
    chk("lw12_raddr", last_raddr, 32'd4);
    chk("lw12_c", g_rdata, 32'hDEAD55EF);
`endif
    run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, "illegal");
    chk("illegal_err_c", g_err, 1);

    // reset during RMW_RD of SH
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'b01;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h1234;
    w0 = wr_cnt;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_rmw_rd", bus.mem_read, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_mem_write", bus.mem_write, 0);
    chk("abort_ready", bus.req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_write", wr_cnt - w0, 0);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw_after_abort");
    chk("lw_after_abort_c", g_rdata, 32'hDEAD55EF);

    // held req_valid with three back-to-back loads
    run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11112222, "t6_sw0");
    run_req(1'b1, 2'b10, 1'b0, 32'h24, 32'h33334444, "t6_sw1");
    run_req(1'b1, 2'b10, 1'b0, 32'h28, 32'h55556666, "t6_sw2");
    t6_addr[0] = 32'h20; t6_addr[1] = 32'h24; t6_addr[2] = 32'h28;
    for (int n = 0; n < 3; n++) begin
      ref_op(1'b0, 2'b10, 1'b0, t6_addr[n], 32'h0, d_rd, d_er, d_lat, d_nr, d_nw);
      t6_exp.push_back(d_rd);
    end
    acc_base = acc_q.size();
    bad_ready = 0; busy = 1'b0; i = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = t6_addr[0];
    for (int cyc = 0; cyc < 40 && t6_got.size() < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (busy && bus.req_ready) bad_ready++;
      if (bus.resp_valid) begin
        t6_got.push_back(bus.resp_rdata);
        busy = 1'b0;
      end
      if (bus.req_ready && i < 3) begin
        @(posedge clk);
        #1;
        busy = 1'b1;
        i++;
        if (i < 3) bus.req_addr = t6_addr[i];
        else bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    chk("t6_resp_count", t6_got.size(), 3);
    chk("t6_accept_count", acc_q.size() - acc_base, 3);
    chk("t6_ready_busy", bad_ready, 0);
    for (int n = 0; n < 3; n++) begin
      if (n < t6_got.size()) chk($sformatf("t6_rdata%0d", n), t6_got[n], t6_exp[n]);
      if (acc_base + n < acc_q.size()) chk($sformatf("t6_acc%0d", n), acc_q[acc_base + n], t6_addr[n]);
    end

    // randomized mix, including wrap of high address bits and size=11
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          idx;
      idx = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(1020, 1023);
      sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a   = ($urandom & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
      run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
              $sformatf("rnd%0d", n));
    end

    chk("no_rd_wr_overlap", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
